// File: rtl/dec8_pkg.sv
// ---------------------------------------------------------------------------
// dec8_pkg
// Shared types and helpers for the dec8_strobe decoder slice.
//   state_t   : controller states (idle, pulse being held, idle gap)
//   onehot8   : converts a 3-bit binary code into an 8-bit one-hot word
//   cnt_width : counter width needed to hold max(PULSE_LEN, GAP, 1)
//   CNT_W     : counter width for the default PULSE_LEN/GAP configuration
// ---------------------------------------------------------------------------
package dec8_pkg;

   // Controller states. The ST_ prefix keeps the GAP literal from colliding
   // with the GAP parameter of the top level.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam int CODE_W           = 3;
   localparam int DEF_PULSE_LEN    = 4;
   localparam int DEF_GAP          = 1;
   localparam int DEF_FIFO_DEPTH   = 4;

   // The counter only ever holds PULSE_LEN-1 or GAP-1, but one extra bit of
   // headroom keeps the width sane when both parameters are 1 or 0.
   function automatic int cnt_width(input int pulse_len, input int gap);
      int m;
      m = pulse_len;
      if (gap > m) begin
         m = gap;
      end
      if (m < 1) begin
         m = 1;
      end
      return $clog2(m) + 1;
   endfunction

   localparam int CNT_W = cnt_width(DEF_PULSE_LEN, DEF_GAP);

   // Bit position equal to the binary code is set, all other bits clear.
   function automatic logic [7:0] onehot8(input logic [2:0] code);
      onehot8 = 8'b0000_0001 << code;
   endfunction

endpackage

// File: rtl/dec8_fifo.sv
// ---------------------------------------------------------------------------
// dec8_fifo
// Small synchronous FIFO that buffers codes for the strobe decoder.
// Occupancy, full and empty are all registered so downstream control never
// sees a combinational path from push/pop back into the flags.
//   clk      in         : clock, rising edge
//   rst_n    in         : synchronous active-low reset
//   push     in         : write wr_data at the tail (ignored when full)
//   wr_data  in  WIDTH  : data to write
//   pop      in         : advance the head (ignored when empty)
//   rd_data  out WIDTH  : current head entry (valid while !empty)
//   level    out        : number of stored entries
//   empty    out        : registered level == 0
//   in_ready out        : registered !full, held low during reset
// ---------------------------------------------------------------------------
module dec8_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     in_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d;
   logic [LVL_W-1:0] level_q;
   logic [LVL_W-1:0] level_d;
   logic             full_q;
   logic             full_d;
   logic             empty_q;
   logic             empty_d;
   logic             ready_q;
   logic             ready_d;
   logic             wr_en;
   logic             rd_en;

   // Guard the requests against the registered flags so a stray push while
   // full or pop while empty can never corrupt the pointers or the count.
   assign wr_en = push && !full_q;
   assign rd_en = pop && !empty_q;

   // Next-state for storage, pointers and occupancy. Pointers wrap for free
   // because DEPTH is a power of two; level is what tells full from empty.
   // The flags are derived from the next level so they are registered
   // alongside it rather than decoded after the flop.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (wr_en) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      full_d  = (level_d == LVL_W'(DEPTH));
      empty_d = (level_d == '0);
      ready_d = !full_d;
   end

   // State register. ready_q resets low so the producer sees no room while
   // reset is held, and comes up high on the first clock after release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ready_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ready_q  <= ready_d;
      end
   end

   // The head is read straight out of the storage flops. A freshly written
   // entry only lands in storage at the clock edge, so it cannot fall through.
   assign rd_data  = mem_q[rd_ptr_q];
   assign level    = level_q;
   assign empty    = empty_q;
   assign in_ready = ready_q;

endmodule

// File: rtl/dec8_strobe.sv
// ---------------------------------------------------------------------------
// dec8_strobe
// Registered 3-to-8 one-hot decoder with an input FIFO and timed strobes.
// Each queued code is replayed as a one-hot word on d_out for PULSE_LEN
// cycles, optionally followed by GAP all-zero cycles.
//   clk       in     : clock, rising edge
//   rst_n     in     : synchronous active-low reset
//   in_valid  in     : in_code is valid
//   in_ready  out    : FIFO can accept a code (registered !full)
//   in_code   in  3  : binary code 0..7
//   en        in     : allows the next code to be popped; never aborts one
//   d_out     out 8  : registered one-hot strobe, zero when idle or in gap
//   out_valid out    : d_out is non-zero
//   busy      out    : controller active or codes still queued
//   level     out    : FIFO occupancy
// ---------------------------------------------------------------------------
module dec8_strobe
   import dec8_pkg::*;
#(
   parameter int PULSE_LEN  = 4,
   parameter int GAP        = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    in_code,
   input  logic                          en,
   output logic [7:0]                    d_out,
   output logic                          out_valid,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int              CTR_W      = cnt_width(PULSE_LEN, GAP);
   localparam bit              HAS_GAP    = (GAP > 0);
   localparam logic [CTR_W-1:0] PULSE_LOAD = CTR_W'(PULSE_LEN - 1);
   localparam logic [CTR_W-1:0] GAP_LOAD   = CTR_W'((GAP > 0) ? (GAP - 1) : 0);

   state_t           state_q;
   state_t           state_d;
   logic [CTR_W-1:0] cnt_q;
   logic [CTR_W-1:0] cnt_d;
   logic [7:0]       d_out_q;
   logic [7:0]       d_out_d;
   logic             fifo_push;
   logic             fifo_pop;
   logic [2:0]       fifo_code;
   logic             fifo_empty;
   logic             can_pop;

   assign fifo_push = in_valid && in_ready;

   // Code buffer between the command stream and the strobe controller.
   dec8_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .wr_data  (in_code),
      .pop      (fifo_pop),
      .rd_data  (fifo_code),
      .level    (level),
      .empty    (fifo_empty),
      .in_ready (in_ready)
   );

   // en is only consulted at the point where a new code would be started,
   // which is what lets a pulse or gap in progress run to completion.
   assign can_pop = en && !fifo_empty;

   // Strobe controller. The counter is loaded with length-1 on entry so the
   // state lasts exactly PULSE_LEN (or GAP) cycles, counting down to zero.
   // The end of a gap applies the same pop rule as idle in the same cycle,
   // so pulse starts are spaced PULSE_LEN+GAP apart with a non-empty FIFO.
   // With no gap, the end of a pulse loads the next code directly, giving
   // back-to-back strobes with no zero cycle between them.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      d_out_d  = d_out_q;
      fifo_pop = 1'b0;

      case (state_q)
         ST_IDLE: begin
            d_out_d = '0;
            if (can_pop) begin
               fifo_pop = 1'b1;
               d_out_d  = onehot8(fifo_code);
               cnt_d    = PULSE_LOAD;
               state_d  = ST_PULSE;
            end
         end

         ST_PULSE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CTR_W'(1);
            end else if (HAS_GAP) begin
               d_out_d = '0;
               cnt_d   = GAP_LOAD;
               state_d = ST_GAP;
            end else if (can_pop) begin
               fifo_pop = 1'b1;
               d_out_d  = onehot8(fifo_code);
               cnt_d    = PULSE_LOAD;
               state_d  = ST_PULSE;
            end else begin
               d_out_d = '0;
               state_d = ST_IDLE;
            end
         end

         ST_GAP: begin
            d_out_d = '0;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CTR_W'(1);
            end else if (can_pop) begin
               fifo_pop = 1'b1;
               d_out_d  = onehot8(fifo_code);
               cnt_d    = PULSE_LOAD;
               state_d  = ST_PULSE;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            d_out_d = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and output register. Reset mid-pulse simply drops
   // everything; the FIFO is cleared on the same edge so queued codes vanish.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         d_out_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_out_q <= d_out_d;
      end
   end

   assign d_out     = d_out_q;
   assign out_valid = (d_out_q != '0);
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dec8_strobe.sv
// ---------------------------------------------------------------------------
// tb_dec8_strobe
// Self-checking bench for dec8_strobe. One instance uses PULSE_LEN=4, GAP=1,
// FIFO_DEPTH=4; a second instance with GAP=0 covers back-to-back strobes.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_dec8_strobe;

   localparam int PL = 4;
   localparam int GP = 1;
   localparam int FD = 4;

   typedef struct {
      logic       in_valid;
      logic [2:0] in_code;
      logic       en;
      logic [7:0] exp_out;
      logic       exp_valid;
      logic       exp_ready;
      logic [2:0] exp_level;
      logic       exp_busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_code;
   logic       en;
   logic [7:0] d_out;
   logic       out_valid;
   logic       busy;
   logic [2:0] level;

   logic       in_valid0;
   logic       in_ready0;
   logic [2:0] in_code0;
   logic       en0;
   logic [7:0] d_out0;
   logic       out_valid0;
   logic       busy0;
   logic [2:0] level0;

   int         vec_count = 0;
   int         miss_count = 0;
   int         pulse_count = 0;
   logic [2:0] exp_q [$];
   bit         stall_seen;
   vec_t       vecs [22];

   always #5 clk = ~clk;

   dec8_strobe #(.PULSE_LEN(PL), .GAP(GP), .FIFO_DEPTH(FD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_code   (in_code),
      .en        (en),
      .d_out     (d_out),
      .out_valid (out_valid),
      .busy      (busy),
      .level     (level)
   );

   dec8_strobe #(.PULSE_LEN(PL), .GAP(0), .FIFO_DEPTH(FD)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid0),
      .in_ready  (in_ready0),
      .in_code   (in_code0),
      .en        (en0),
      .d_out     (d_out0),
      .out_valid (out_valid0),
      .busy      (busy0),
      .level     (level0)
   );

   function automatic logic [7:0] expOneHot(input logic [2:0] c);
      logic [7:0] table8 [8];
      table8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      return table8[c];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      in_valid = v.in_valid;
      in_code  = v.in_code;
      en       = v.en;
   endtask

   task automatic alignDrive();
      @(posedge clk);
      #1;
   endtask

   // Presents one code and holds it until the handshake completes.
   task automatic pushCode(input logic [2:0] c);
      bit accepted;
      accepted = 1'b0;
      in_valid = 1'b1;
      in_code  = c;
      for (int t = 0; t < 60 && !accepted; t++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted = 1'b1;
         end else if (!stall_seen) begin
            stall_seen = 1'b1;
            checkOutput("stall_level", 32'(level), 32'(FD));
         end
         alignDrive();
      end
      if (!accepted) begin
         vec_count++;
         miss_count++;
         $display("[TB] FAIL push_timeout: code %0d never accepted, required accept within 60 cycles", c);
      end
   endtask

   task automatic waitDrain(input string name);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0 && d_out == 8'h00) begin
            done = 1'b1;
         end
      end
      checkOutput({name, "_drained"}, 32'(done), 32'd1);
      checkOutput({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      alignDrive();
   endtask

   // Scoreboard monitor. Accepted codes are queued on the falling edge before
   // the handshake edge; each new non-zero word on d_out pops one entry and
   // must match it, and each completed strobe must last exactly PL cycles.
   // A low rst_n means the next edge wipes the DUT, so the queue is dropped.
   logic [7:0] mon_prev = 8'h00;
   int         mon_run = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         mon_prev = 8'h00;
         mon_run  = 0;
      end else begin
         if (d_out != mon_prev) begin
            if (mon_prev != 8'h00) begin
               checkOutput("pulse_len", 32'(mon_run), 32'(PL));
            end
            if (d_out != 8'h00) begin
               pulse_count++;
               if (exp_q.size() == 0) begin
                  vec_count++;
                  miss_count++;
                  $display("[TB] FAIL sb_unexpected: got d_out 0x%0h, required no pulse (queue empty)", d_out);
               end else begin
                  checkOutput("sb_code", 32'(d_out), 32'(expOneHot(exp_q.pop_front())));
               end
               mon_run = 1;
            end else begin
               mon_run = 0;
            end
         end else if (d_out != 8'h00) begin
            mon_run++;
         end
         mon_prev = d_out;
         if (in_valid && in_ready) begin
            exp_q.push_back(in_code);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      logic [7:0] exp0 [11];

      // in_valid, in_code, en | d_out, out_valid, in_ready, level, busy
      vecs[0]  = '{1'b1, 3'd5, 1'b1, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1};
      vecs[1]  = '{1'b0, 3'd0, 1'b1, 8'h20, 1'b1, 1'b1, 3'd0, 1'b1};
      vecs[2]  = '{1'b0, 3'd0, 1'b1, 8'h20, 1'b1, 1'b1, 3'd0, 1'b1};
      vecs[3]  = '{1'b0, 3'd0, 1'b1, 8'h20, 1'b1, 1'b1, 3'd0, 1'b1};
      vecs[4]  = '{1'b0, 3'd0, 1'b1, 8'h20, 1'b1, 1'b1, 3'd0, 1'b1};
      vecs[5]  = '{1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1};
      vecs[6]  = '{1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0};
      vecs[7]  = '{1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1};
      vecs[8]  = '{1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1};
      vecs[9]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1};
      vecs[10] = '{1'b0, 3'd0, 1'b1, 8'h04, 1'b1, 1'b1, 3'd1, 1'b1};
      vecs[11] = '{1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b1, 3'd1, 1'b1};
      vecs[12] = '{1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b1, 3'd1, 1'b1};
      vecs[13] = '{1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b1, 3'd1, 1'b1};
      vecs[14] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1};
      vecs[15] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b1};
      vecs[16] = '{1'b0, 3'd0, 1'b1, 8'h80, 1'b1, 1'b1, 3'd0, 1'b1};
      vecs[17] = '{1'b0, 3'd0, 1'b1, 8'h80, 1'b1, 1'b1, 3'd0, 1'b1};
      vecs[18] = '{1'b0, 3'd0, 1'b1, 8'h80, 1'b1, 1'b1, 3'd0, 1'b1};
      vecs[19] = '{1'b0, 3'd0, 1'b1, 8'h80, 1'b1, 1'b1, 3'd0, 1'b1};
      vecs[20] = '{1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1};
      vecs[21] = '{1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_code   = 3'd0;
      en        = 1'b0;
      in_valid0 = 1'b0;
      in_code0  = 3'd0;
      en0       = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_d_out", 32'(d_out), 32'h0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_level", 32'(level), 32'h0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
      alignDrive();
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("ready_after_release", 32'(in_ready), 32'h1);
      checkOutput("ready0_after_release", 32'(in_ready0), 32'h1);

      // Table: basic strobe timing, then en gating with a mid-pulse en drop
      alignDrive();
      applyStimulus(vecs[0]);
      for (int i = 0; i < 22; i++) begin
         alignDrive();
         if (i + 1 < 22) begin
            applyStimulus(vecs[i + 1]);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         checkOutput($sformatf("row%0d_d_out", i), 32'(d_out), 32'(vecs[i].exp_out));
         checkOutput($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         checkOutput($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         checkOutput($sformatf("row%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
         checkOutput($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      end
      alignDrive();

      // All codes back-to-back: order and widths checked by the scoreboard,
      // input must stall once four codes are queued
      en = 1'b1;
      stall_seen = 1'b0;
      base = pulse_count;
      for (int c = 0; c < 8; c++) begin
         pushCode(3'(c));
      end
      in_valid = 1'b0;
      checkOutput("all_codes_stall_seen", 32'(stall_seen), 32'd1);
      waitDrain("all_codes");
      checkOutput("all_codes_pulses", 32'(pulse_count - base), 32'd8);

      // Full boundary: fill with en low, then pop while in_valid stays high
      en = 1'b0;
      base = pulse_count;
      for (int c = 1; c <= 4; c++) begin
         pushCode(3'(c));
      end
      in_code = 3'd5;
      @(negedge clk);
      checkOutput("full_level", 32'(level), 32'd4);
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      alignDrive();
      en = 1'b1;
      @(negedge clk);
      checkOutput("pop_cycle_in_ready", 32'(in_ready), 32'd0);
      alignDrive();
      @(negedge clk);
      checkOutput("after_pop_level", 32'(level), 32'd3);
      checkOutput("after_pop_in_ready", 32'(in_ready), 32'd1);
      checkOutput("after_pop_d_out", 32'(d_out), 32'h02);
      alignDrive();
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("refill_level", 32'(level), 32'd4);
      checkOutput("refill_in_ready", 32'(in_ready), 32'd0);
      waitDrain("full_boundary");
      checkOutput("full_boundary_pulses", 32'(pulse_count - base), 32'd5);

      // GAP=0 instance: code 3 then 6 must be contiguous
      for (int k = 0; k < 11; k++) begin
         exp0[k] = 8'h00;
      end
      for (int k = 1; k <= 4; k++) begin
         exp0[k]     = 8'h08;
         exp0[k + 4] = 8'h40;
      end
      en0       = 1'b1;
      in_valid0 = 1'b1;
      in_code0  = 3'd3;
      alignDrive();
      in_code0  = 3'd6;
      alignDrive();
      in_valid0 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checkOutput($sformatf("gap0_c%0d_d_out", k), 32'(d_out0), 32'(exp0[k]));
         checkOutput($sformatf("gap0_c%0d_out_valid", k), 32'(out_valid0), 32'(exp0[k] != 8'h00));
      end
      checkOutput("gap0_busy_end", 32'(busy0), 32'd0);
      alignDrive();

      // Mid-operation reset during the second cycle of a pulse
      base = pulse_count;
      en       = 1'b1;
      in_valid = 1'b1;
      in_code  = 3'd2;
      alignDrive();
      in_code  = 3'd3;
      alignDrive();
      in_code  = 3'd4;
      alignDrive();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      checkOutput("pre_reset_d_out", 32'(d_out), 32'h04);
      @(negedge clk);
      checkOutput("mid_rst_d_out", 32'(d_out), 32'h0);
      checkOutput("mid_rst_level", 32'(level), 32'h0);
      checkOutput("mid_rst_busy", 32'(busy), 32'h0);
      checkOutput("mid_rst_out_valid", 32'(out_valid), 32'h0);
      alignDrive();
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      checkOutput("post_rst_d_out", 32'(d_out), 32'h0);
      checkOutput("post_rst_level", 32'(level), 32'h0);
      checkOutput("post_rst_pulses", 32'(pulse_count - base), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule

// File: doc/dec8_strobe.md
# dec8_strobe

Registered 3-to-8 one-hot decoder with input buffering and timed strobe output, the receive-side counterpart of the 8:3 encoder. It accepts 3-bit binary codes over a valid/ready handshake and queues them in a small FIFO. Each code is replayed as a one-hot pulse on `d_out`, held for a programmable number of cycles, with an optional idle gap between pulses. It drives one-hot select/strobe lines from a binary command stream.

## Interface
- `PULSE_LEN`, 4: cycles each one-hot word is held; legal range ≥1.
- `GAP`, 1: all-zero cycles inserted after each pulse; legal range ≥0.
- `FIFO_DEPTH`, 4: code buffer entries; must be a power of two, ≥2.

Ports (synchronous reset, active-low):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset.
- `in_valid` in 1: `in_code` is valid.
- `in_ready` out 1: FIFO can accept; equals !full, from registered count only.
- `in_code` in 3: binary code 0..7.
- `en` in 1: start enable; gates pops only.
- `d_out` out 8: registered one-hot output, bit `in_code` set; zero when idle or in gap.
- `out_valid` out 1: high exactly while `d_out` is non-zero.
- `busy` out 1: high when state ≠ IDLE or FIFO non-empty.
- `level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- Push when `in_valid && in_ready` at an edge; code written to the FIFO tail.
- FSM states:
  - **IDLE**: if FIFO non-empty and `en` is high, pop the head, load `d_out = 8'b1 << code`, load the counter with PULSE_LEN-1, and go to PULSE. Otherwise stay in IDLE with `d_out` = 0.
  - **PULSE**: when the counter ≠ 0, decrement and hold `d_out`. When the counter = 0:
    - If GAP > 0: clear `d_out`, load the counter with GAP-1, and go to GAP.
    - Else if FIFO non-empty and `en` is high: pop and load the next code back-to-back, staying in PULSE.
    - Else: clear `d_out` and go to IDLE.
  - **GAP**: when the counter ≠ 0, decrement. When the counter = 0, apply the IDLE pop rule in the same cycle: pop and go to PULSE, or go to IDLE.
- `en` low never aborts a pulse or gap in progress. It only blocks the next pop; FIFO contents are retained.
- No fall-through: a code pushed at edge t is poppable no earlier than edge t+1.
- Push and pop in the same edge are legal whenever `in_ready` is high; `level` is unchanged.
- When full, `in_ready` stays low for the cycle in which a pop occurs and rises the following cycle.
- Pointers wrap modulo FIFO_DEPTH; `level` distinguishes full from empty.
- Reset values: `d_out`=0, `out_valid`=0, `busy`=0, `level`=0, state=IDLE, pointers=0. `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Reset asserted mid-pulse clears everything at that edge; queued codes are discarded.

## Timing
- Latency: push at edge t, `d_out` one-hot from edge t+1 (IDLE, `en` high).
- Pulse width is exactly PULSE_LEN cycles. Spacing between pulse starts is PULSE_LEN+GAP when the FIFO is non-empty.
- With GAP=0 and a non-empty FIFO, consecutive pulses are contiguous with no zero cycle in between.
- Sustained throughput is one code per PULSE_LEN+GAP cycles. Input stalls via `in_ready` once FIFO_DEPTH codes are queued.

## Structure
- Package `dec8_pkg`:
  - state enum {IDLE, PULSE, GAP};
  - function `onehot8(logic [2:0])`;
  - localparam counter width = $clog2(max(PULSE_LEN, GAP, 1)) + 1.
- Sub-module `dec8_fifo`: synchronous FIFO parameterized by width (3) and depth, with registered `level`, `full`, and `empty`.
- The top contains the FSM, the counter, and the output register only.

## Test plan
- **Reset/basic**: PULSE_LEN=4, GAP=1; push code 5 at edge 2. Expect `d_out`=8'h20 for cycles 3–6, 0 at cycle 7, then IDLE. Check `out_valid` matches.
- **All codes**: push 0..7 back-to-back. Expect `d_out` sequence 01, 02, 04, 08, 10, 20, 40, 80, each 4 cycles, separated by 1 zero cycle. `in_ready` drops after 4 queued codes.
- **GAP=0 contiguity**: push 3 then 6. Expect 8'h08 for 4 cycles immediately followed by 8'h40 for 4 cycles, with no zero cycle.
- **`en` gating**: `en`=0 and push 2, 7. Expect `d_out`=0 and `level`=2. Raise `en`: pulses 8'h04 then 8'h80. Dropping `en` mid-pulse does not truncate the 8'h04 pulse.
- **Full boundary**: fill to 4 and hold `in_valid`. In the pop cycle, `in_ready` is still 0; it rises the next cycle. No code is lost or duplicated (scoreboard).
- **Mid-operation reset**: `rst_n` low during the second cycle of a pulse. Next cycle `d_out`=0, `level`=0, `busy`=0; queued codes are never emitted.
